instr_prefetch_queue: RTL and testbench

INSTR_PREFETCH_QUEUE -- requirements
Module: instr_prefetch_queue

---
 rtl/fetch_pkg.sv | 25 ++
 rtl/prefetch_fifo.sv | 58 +++++
 rtl/instr_prefetch_queue.sv | 139 +++++++++++++
 tb/tb_instr_prefetch_queue.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction prefetch queue.
package fetch_pkg;

   localparam int XLEN = 32;
   localparam logic [XLEN-1:0] PC_STEP = 32'd4;

   // Prefetch control states
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      FLUSH = 2'd2
   } fetch_state_t;

   // One queued fetch result: address and the instruction word found there
   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] instr;
   } fetch_entry_t;

   // Force a fetch address onto a word boundary
   function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
      return {pc[XLEN-1:2], 2'b00};
   endfunction

endpackage

// File: rtl/prefetch_fifo.sv
// prefetch_fifo: DEPTH-entry synchronous FIFO of fetch entries with a
// synchronous flush. Head entry is visible on pop_data whenever not empty.
module prefetch_fifo
   import fetch_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                         clock,
   input  logic                         reset,
   input  logic                         flush,
   input  logic                         push,
   input  fetch_entry_t                 push_data,
   input  logic                         pop,
   output fetch_entry_t                 pop_data,
   output logic                         full,
   output logic                         empty,
   output logic [$clog2(DEPTH+1)-1:0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);

   fetch_entry_t    mem [DEPTH];
   logic [AW-1:0]   wr_ptr_reg;
   logic [AW-1:0]   rd_ptr_reg;
   logic [CW-1:0]   count_reg;

   // Pointer and occupancy bookkeeping; flush empties the queue in one cycle
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else if (flush) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (push)
            wr_ptr_reg <= wr_ptr_reg + AW'(1);
         if (pop)
            rd_ptr_reg <= rd_ptr_reg + AW'(1);
         count_reg <= count_reg + CW'(push) - CW'(pop);
      end
   end

   // Entry storage; contents need no reset because count gates visibility
   always_ff @(posedge clock) begin
      if (push && !flush)
         mem[wr_ptr_reg] <= push_data;
   end

   assign pop_data = mem[rd_ptr_reg];
   assign count    = count_reg;
   assign full     = (count_reg == CW'(DEPTH));
   assign empty    = (count_reg == '0);

endmodule

// File: rtl/instr_prefetch_queue.sv
// instr_prefetch_queue: issues sequential instruction fetches, tracks
// in-flight requests with a credit limit of DEPTH, queues returned words and
// discards stale responses after a redirect.
// Optional macro PREFETCH_BYPASS_EN: a response arriving while the queue is
// empty is forwarded to out_* in the same cycle.
module instr_prefetch_queue
   import fetch_pkg::*;
#(
   parameter int              DEPTH    = 4,
   parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             redirect_valid,
   input  logic [XLEN-1:0]  redirect_pc,
   output logic             imem_req_valid,
   input  logic             imem_req_ready,
   output logic [XLEN-1:0]  imem_req_addr,
   input  logic             imem_rsp_valid,
   input  logic [XLEN-1:0]  imem_rsp_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [XLEN-1:0]  out_instr,
   output logic [XLEN-1:0]  out_pc
);

   localparam int CW = $clog2(DEPTH+1);

   fetch_state_t    state_reg, state_next;
   logic [XLEN-1:0] fetch_pc_reg, fetch_pc_next;
   logic [XLEN-1:0] rsp_pc_reg, rsp_pc_next;
   logic [CW-1:0]   outstanding_reg, outstanding_next;
   logic [CW-1:0]   drop_cnt_reg, drop_cnt_next;

   logic            fifo_push, fifo_pop, fifo_full, fifo_empty;
   logic [CW-1:0]   fifo_count;
   fetch_entry_t    fifo_head, push_entry, out_entry;
   logic            out_valid_int;

   logic            req_fire, rsp_accept, rsp_keep, rsp_drop;
   logic [CW:0]     credits_used;

   // Every request in flight or word already queued consumes one slot
   assign credits_used   = {1'b0, outstanding_reg} + {1'b0, fifo_count};
   assign imem_req_valid = (state_reg == RUN) && (credits_used < (CW+1)'(DEPTH));
   assign imem_req_addr  = fetch_pc_reg;
   assign req_fire       = imem_req_valid && imem_req_ready;

   // Responses with nothing outstanding are spurious and ignored
   assign rsp_accept = imem_rsp_valid && (outstanding_reg != '0);
   assign rsp_keep   = rsp_accept && (drop_cnt_reg == '0);
   assign rsp_drop   = rsp_accept && (drop_cnt_reg != '0);

   assign push_entry.pc    = rsp_pc_reg;
   assign push_entry.instr = imem_rsp_data;

`ifdef PREFETCH_BYPASS_EN
   // Empty queue: forward the arriving word directly; store it only if not taken
   assign out_valid_int = !fifo_empty || rsp_keep;
   assign out_entry     = fifo_empty ? push_entry : fifo_head;
   assign fifo_push     = rsp_keep && !redirect_valid && !fifo_full &&
                          !(fifo_empty && out_ready);
   assign fifo_pop      = !fifo_empty && out_ready && !redirect_valid;
`else
   // Output is driven purely from queue storage
   assign out_valid_int = !fifo_empty;
   assign out_entry     = fifo_head;
   assign fifo_push     = rsp_keep && !redirect_valid && !fifo_full;
   assign fifo_pop      = out_valid_int && out_ready && !redirect_valid;
`endif

   assign out_valid = out_valid_int;
   assign out_instr = out_valid_int ? out_entry.instr : '0;
   assign out_pc    = out_valid_int ? out_entry.pc    : '0;

   prefetch_fifo #(
      .DEPTH     (DEPTH)
   ) u_fifo (
      .clock     (clock),
      .reset     (reset),
      .flush     (redirect_valid),
      .push      (fifo_push),
      .push_data (push_entry),
      .pop       (fifo_pop),
      .pop_data  (fifo_head),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (fifo_count)
   );

   // Next-state, PC and counter update; redirect overrides everything else
   always_comb begin
      state_next       = state_reg;
      fetch_pc_next    = fetch_pc_reg;
      rsp_pc_next      = rsp_pc_reg;
      drop_cnt_next    = drop_cnt_reg;
      outstanding_next = outstanding_reg + CW'(req_fire) - CW'(rsp_accept);

      if (req_fire)
         fetch_pc_next = fetch_pc_reg + PC_STEP;
      if (rsp_keep)
         rsp_pc_next = rsp_pc_reg + PC_STEP;
      if (rsp_drop)
         drop_cnt_next = drop_cnt_reg - CW'(1);

      unique case (state_reg)
         IDLE:    state_next = RUN;
         RUN:     state_next = RUN;
         FLUSH:   if (drop_cnt_next == '0) state_next = RUN;
         default: state_next = IDLE;
      endcase

      // Everything still in flight after this cycle belongs to the old stream
      if (redirect_valid) begin
         fetch_pc_next = align_pc(redirect_pc);
         rsp_pc_next   = align_pc(redirect_pc);
         drop_cnt_next = outstanding_next;
         state_next    = (outstanding_next != '0) ? FLUSH : RUN;
      end
   end

   // Control registers with asynchronous active-low reset
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_reg       <= IDLE;
         fetch_pc_reg    <= RESET_PC;
         rsp_pc_reg      <= RESET_PC;
         outstanding_reg <= '0;
         drop_cnt_reg    <= '0;
      end else begin
         state_reg       <= state_next;
         fetch_pc_reg    <= fetch_pc_next;
         rsp_pc_reg      <= rsp_pc_next;
         outstanding_reg <= outstanding_next;
         drop_cnt_reg    <= drop_cnt_next;
      end
   end

endmodule

// File: tb/tb_instr_prefetch_queue.sv
// tb_instr_prefetch_queue: directed bench with a 1-cycle in-order memory model.
module tb_instr_prefetch_queue;

   localparam int          DEPTH    = 4;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = 32'h0;
   logic        imem_req_valid;
   logic        imem_req_ready = 1'b0;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid = 1'b0;
   logic [31:0] imem_rsp_data = 32'h0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] out_instr;
   logic [31:0] out_pc;

   always #5 clock = ~clock;

   instr_prefetch_queue #(
      .DEPTH          (DEPTH),
      .RESET_PC       (RESET_PC)
   ) dut (
      .clock          (clock),
      .reset          (reset),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .imem_req_valid (imem_req_valid),
      .imem_req_ready (imem_req_ready),
      .imem_req_addr  (imem_req_addr),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_instr      (out_instr),
      .out_pc         (out_pc)
   );

   int n_checks = 0;
   int n_errors = 0;

   bit          mem_ready = 1'b1;
   bit          mem_hold  = 1'b0;
   logic [31:0] pend_q[$];
   logic [31:0] fire_log[$];
   int          fires = 0;
   int          pops  = 0;
   logic [31:0] exp_out_pc = RESET_PC;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return a ^ 32'hC0DE_5A00;
   endfunction

   // One clock cycle: memory model drives response, then sample and log transactions
   task automatic cycle();
      logic        rsp_given, fire_s, pop_s;
      logic [31:0] addr_s, opc_s, oins_s;
      rsp_given      = !mem_hold && (pend_q.size() > 0);
      imem_rsp_valid = rsp_given;
      imem_rsp_data  = rsp_given ? mem_word(pend_q[0]) : 32'h0;
      imem_req_ready = mem_ready;
      #1;
      fire_s = imem_req_valid && imem_req_ready;
      addr_s = imem_req_addr;
      pop_s  = out_valid && out_ready && !redirect_valid;
      opc_s  = out_pc;
      oins_s = out_instr;
      @(posedge clock);
      if (rsp_given) void'(pend_q.pop_front());
      if (fire_s) begin
         pend_q.push_back(addr_s);
         fire_log.push_back(addr_s);
         fires++;
         $display("req  addr=0x%08h", addr_s);
      end
      if (pop_s) begin
         $display("pop  pc=0x%08h instr=0x%08h", opc_s, oins_s);
         check_eq("pop_pc", opc_s, exp_out_pc);
         check_eq("pop_instr", oins_s, mem_word(exp_out_pc));
         exp_out_pc += 32'd4;
         pops++;
      end
      #1;
   endtask

   task automatic run_until_pops(input int target, input int budget, input string tag);
      int k = 0;
      while (pops < target && k < budget) begin
         cycle();
         k++;
      end
      check_eq(tag, 32'(pops), 32'(target));
   endtask

   task automatic do_reset();
      reset          = 1'b0;
      redirect_valid = 1'b0;
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 32'h0;
      out_ready      = 1'b0;
      mem_hold       = 1'b0;
      pend_q.delete();
      fire_log.delete();
      fires = 0;
      pops  = 0;
      #1;
      check_eq("rst_req_valid", 32'(imem_req_valid), 32'd0);
      check_eq("rst_req_addr", imem_req_addr, RESET_PC);
      check_eq("rst_out_valid", 32'(out_valid), 32'd0);
      check_eq("rst_out_instr", out_instr, 32'h0);
      check_eq("rst_out_pc", out_pc, 32'h0);
      repeat (2) @(posedge clock);
      #1;
      reset      = 1'b1;
      exp_out_pc = RESET_PC;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [31:0] wexp [3];
      int idx;
      #2;
      do_reset();

      // Reset release: IDLE -> RUN, first request at RESET_PC
      mem_ready = 1'b1;
      cycle();
      check_eq("run_req_valid", 32'(imem_req_valid), 32'd1);
      check_eq("run_req_addr", imem_req_addr, RESET_PC);

      // Streaming, one instruction per cycle
      out_ready = 1'b1;
      cycle();
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_word(pend_q[0]);
      #1;
`ifdef PREFETCH_BYPASS_EN
      check_eq("first_rsp_out_valid", 32'(out_valid), 32'd1);
`else
      check_eq("first_rsp_out_valid", 32'(out_valid), 32'd0);
`endif
      repeat (4) cycle();
      idx = pops;
      repeat (8) cycle();
      check_eq("steady_pops", 32'(pops - idx), 32'd8);

      // Redirect to unaligned 0x203 with a response and a pop in the same cycle
      check_eq("pre_redir_out_valid", 32'(out_valid), 32'd1);
      check_eq("pre_redir_pending", 32'(pend_q.size()), 32'd1);
      redirect_valid = 1'b1;
      redirect_pc    = 32'h0000_0203;
      cycle();
      redirect_valid = 1'b0;
      check_eq("redir_out_valid", 32'(out_valid), 32'd0);
      check_eq("redir_out_pc", out_pc, 32'h0);
      check_eq("redir_fetch_addr", imem_req_addr, 32'h0000_0200);
      exp_out_pc = 32'h0000_0200;
      idx = fire_log.size();
      run_until_pops(pops + 3, 20, "redir_pops");
      check_eq("redir_first_req", (fire_log.size() > idx) ? fire_log[idx] : 32'hDEAD_BEEF,
               32'h0000_0200);

      // Address wrap at the top of the 32-bit space
      redirect_valid = 1'b1;
      redirect_pc    = 32'hFFFF_FFF8;
      cycle();
      redirect_valid = 1'b0;
      exp_out_pc = 32'hFFFF_FFF8;
      idx = fire_log.size();
      run_until_pops(pops + 4, 30, "wrap_pops");
      wexp = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000};
      for (int i = 0; i < 3; i++)
         check_eq("wrap_req_addr", (fire_log.size() > idx + i) ? fire_log[idx + i] : 32'hDEAD_BEEF,
                  wexp[i]);

      // Credit limit with decode stalled
      do_reset();
      mem_ready = 1'b1;
      out_ready = 1'b0;
      repeat (10) cycle();
      check_eq("credit_fires", 32'(fires), 32'(DEPTH));
      check_eq("credit_req_valid", 32'(imem_req_valid), 32'd0);
      check_eq("credit_out_valid", 32'(out_valid), 32'd1);
      check_eq("credit_out_pc", out_pc, RESET_PC);
      out_ready = 1'b1;
      cycle();
      out_ready = 1'b0;
      repeat (5) cycle();
      check_eq("credit_refill_fires", 32'(fires), 32'(DEPTH + 1));
      check_eq("credit_refill_req_valid", 32'(imem_req_valid), 32'd0);

      // Redirect with two requests outstanding
      do_reset();
      mem_ready = 1'b1;
      mem_hold  = 1'b1;
      out_ready = 1'b1;
      cycle();
      cycle();
      cycle();
      mem_ready = 1'b0;
      check_eq("flush_outstanding", 32'(fires), 32'd2);
      redirect_valid = 1'b1;
      redirect_pc    = 32'h0000_0100;
      cycle();
      redirect_valid = 1'b0;
      mem_ready = 1'b1;
      mem_hold  = 1'b0;
      check_eq("flush_req_valid_0", 32'(imem_req_valid), 32'd0);
      cycle();
      check_eq("flush_req_valid_1", 32'(imem_req_valid), 32'd0);
      check_eq("flush_out_valid", 32'(out_valid), 32'd0);
      cycle();
      check_eq("flush_done_req_valid", 32'(imem_req_valid), 32'd1);
      check_eq("flush_done_req_addr", imem_req_addr, 32'h0000_0100);
      exp_out_pc = 32'h0000_0100;
      run_until_pops(pops + 2, 20, "flush_pops");

      // Asynchronous reset mid-stream with three entries queued
      do_reset();
      mem_ready = 1'b1;
      out_ready = 1'b0;
      idx = 0;
      while (fires < 3 && idx < 20) begin
         cycle();
         idx++;
      end
      mem_ready = 1'b0;
      repeat (3) cycle();
      check_eq("pre_areset_out_valid", 32'(out_valid), 32'd1);
      reset = 1'b0;
      #1;
      check_eq("areset_req_valid", 32'(imem_req_valid), 32'd0);
      check_eq("areset_req_addr", imem_req_addr, RESET_PC);
      check_eq("areset_out_valid", 32'(out_valid), 32'd0);
      check_eq("areset_out_instr", out_instr, 32'h0);
      check_eq("areset_out_pc", out_pc, 32'h0);
      do_reset();
      mem_ready = 1'b1;
      out_ready = 1'b1;
      run_until_pops(2, 20, "restart_pops");
      check_eq("restart_first_req", (fire_log.size() > 0) ? fire_log[0] : 32'hDEAD_BEEF, RESET_PC);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
